// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative 32-cycle mult/multu/div/divu unit owning the HI/LO registers
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] firstOperand,
  input  logic [WIDTH-1:0] secondOperand,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] prod;
  logic               sa, sb, ge;
  logic [WIDTH-1:0]   am, bm, nrem, q, r;
  logic [WIDTH:0]     sum, part;
  logic [2*WIDTH-1:0] mres;
  // operand magnitudes, one shift-add / shift-subtract step, and final sign correction
  always_comb begin
    sa   = ~op[0] & firstOperand[WIDTH-1];
    sb   = ~op[0] & secondOperand[WIDTH-1];
    am   = sa ? -firstOperand : firstOperand;
    bm   = sb ? -secondOperand : secondOperand;
    sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{prod[0]}}};
    part = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    ge   = part >= {1'b0, m};
    nrem = ge ? part[WIDTH-1:0] - m : part[WIDTH-1:0];
    mres = neg_q ? -prod : prod;
    q    = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    r    = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  end
  // control FSM plus datapath; a zero divisor suppresses quotient negation so lo stays all ones
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      m      <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= (sa ^ sb) & (|secondOperand);
            neg_r  <= sa;
            m      <= op[1] ? bm : am;
            prod   <= {{WIDTH{1'b0}}, op[1] ? am : bm};
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        CALC: begin
          prod <= is_div ? {nrem, prod[WIDTH-2:0], ge} : {sum, prod[WIDTH-1:1]};
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= is_div ? r : mres[2*WIDTH-1:WIDTH];
          lo    <= is_div ? q : mres[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
